// File: rtl/rf_param_pkg.sv
// Shared definitions for the rf_param register file: default parameter
// values and the clear-sweep FSM state encoding.
package rf_param_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_READ_REG = 0;

    // Clear FSM: IDLE serves reads/writes, CLEAR sweeps zeros through the file.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port of rf_param: address decode, hardwired-zero register,
// optional same-cycle write forwarding and optional output register.
module rf_read_port
    import rf_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS,
    parameter int READ_REG = DEF_READ_REG
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   mem,
    input  logic [ADDR_W-1:0]                    ra,
    input  logic                                 wen0,
    input  logic [ADDR_W-1:0]                    wa0,
    input  logic [DATA_W-1:0]                    wd0,
    input  logic                                 wen1,
    input  logic [ADDR_W-1:0]                    wa1,
    input  logic [DATA_W-1:0]                    wd1,
    output logic [DATA_W-1:0]                    rd
);

    logic [DATA_W-1:0] rd_comb;
    logic [DATA_W-1:0] rd_q;

    // Read mux: stored word, overridden by committing writes (port 1 last so
    // it wins), and finally forced to zero for the hardwired register.
    always_comb begin
        // NOTE: assigning a default first on every path keeps this block
        // purely combinational; a missed branch would otherwise infer a latch.
        rd_comb = mem[ra];
        if (BYPASS != 0) begin
            if (wen0 && (wa0 == ra)) rd_comb = wd0;
            if (wen1 && (wa1 == ra)) rd_comb = wd1;
        end
        if ((ZERO_REG != 0) && (ra == '0)) rd_comb = '0;
    end

    // Output register used when reads are configured with one cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_comb;
    end

    assign rd = (READ_REG != 0) ? rd_q : rd_comb;

endmodule

// File: rtl/rf_param.sv
// Parameterised two-write / two-read register file with a hardware clear
// sweep. Storage, write arbitration and the clear FSM live here; the read
// path is delegated to one rf_read_port per read address.
module rf_param
    import rf_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS,
    parameter int READ_REG = DEF_READ_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic              clr_req,
    output logic              busy
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    clr_state_t                   state, state_next;
    logic [ADDR_W-1:0]            cnt, cnt_next;
    logic                         wen0, wen1;

    assign busy = (state == CLEAR);

    // A write commits only when idle and not aimed at the hardwired zero
    // register; the same qualified enables drive the read-port forwarding,
    // so forwarding is naturally off during a sweep.
    assign wen0 = we0 && !busy && !((ZERO_REG != 0) && (wa0 == '0));
    assign wen1 = we1 && !busy && !((ZERO_REG != 0) && (wa1 == '0));

    // Storage update: sweep zeros while clearing, otherwise apply port 0
    // then port 1 so that port 1 wins on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the whole array sits on the async reset because the file
        // must read all zeros while rst is high, which rules out a RAM macro.
        if (rst) begin
            regs <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else begin
            // NOTE: non-blocking assignments here; the later port-1 write
            // overriding port 0 relies on last-NBA-wins, not on ordering of
            // blocking updates.
            if (wen0) regs[wa0] <= wd0;
            if (wen1) regs[wa1] <= wd1;
        end
    end

    // Clear FSM state and sweep counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Clear FSM next state: start the sweep on clr_req, walk every address
    // once, and hold the counter at the last index instead of wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) state_next = IDLE;
                else                 cnt_next   = cnt + 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .READ_REG(READ_REG)
    ) u_rd0 (
        .clk (clk),
        .rst (rst),
        .mem (regs),
        .ra  (ra0),
        .wen0(wen0),
        .wa0 (wa0),
        .wd0 (wd0),
        .wen1(wen1),
        .wa1 (wa1),
        .wd1 (wd1),
        .rd  (rd0)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .READ_REG(READ_REG)
    ) u_rd1 (
        .clk (clk),
        .rst (rst),
        .mem (regs),
        .ra  (ra1),
        .wen0(wen0),
        .wa0 (wa0),
        .wd0 (wd0),
        .wen1(wen1),
        .wa1 (wa1),
        .wd1 (wd1),
        .rd  (rd1)
    );

endmodule
